// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding controlUnit.
// Holds the PC, fetches one word at a time over a req/ready + rvalid handshake,
// latches it into the instruction register and selects the next PC on retire.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        exec_done,
    input  logic        PCSrc,
    input  logic [31:0] ImmOp,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7_5,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        misaligned
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] VALID = 3'd3;
    localparam logic [2:0] HALT  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        mis_q, mis_d;
    logic [31:0] next_pc;

    // Next-state logic: handshake sequencing and next-PC selection on retire
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        mis_d   = mis_q;
        next_pc = PCSrc ? (pc_q + ImmOp) : (pc_q + 32'd4);
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (exec_done) begin
                    if (next_pc[1:0] != 2'b00) begin
                        // Unaligned target: keep the PC of the offending instruction
                        state_d = HALT;
                        mis_d   = 1'b1;
                    end else begin
                        pc_d    = next_pc;
                        state_d = REQ;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            mis_q   <= mis_d;
        end
    end

    // Outputs: handshake decoded from state, fields sliced from the instruction register
    always_comb begin
        imem_req    = (state_q == REQ);
        imem_addr   = (state_q == REQ) ? pc_q : '0;
        instr_valid = (state_q == VALID);
        misaligned  = mis_q;
        instr       = instr_q;
        op          = instr_q[6:0];
        funct3      = instr_q[14:12];
        funct7_5    = instr_q[30];
        pc          = pc_q;
        pc_plus4    = pc_q + 32'd4;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branches, backpressure,
// misaligned halt, wrap-around with stall, and async reset during a fetch.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        exec_done;
    logic        PCSrc;
    logic [31:0] ImmOp;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .exec_done  (exec_done),
        .PCSrc      (PCSrc),
        .ImmOp      (ImmOp),
        .instr      (instr),
        .op         (op),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr_valid(instr_valid),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle just after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        exec_done = 1'b0; PCSrc = 1'b0; ImmOp = '0;
        tick(2);
        // Reset values
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h4);
        chk("rst_instr", instr, 32'h13);
        chk("rst_op", {25'd0, op}, 32'h13);
        chk("rst_f3", {29'd0, funct3}, 32'h0);
        chk("rst_f75", {31'd0, funct7_5}, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'h0);
        chk("rst_mis", {31'd0, misaligned}, 32'h0);

        // Sequential fetch, everything immediate
        rst = 1'b0;
        imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093;
        exec_done = 1'b1; PCSrc = 1'b0;
        chk("idle_req", {31'd0, imem_req}, 32'h0);
        tick(1);
        chk("seq0_req", {31'd0, imem_req}, 32'h1);
        chk("seq0_addr", imem_addr, 32'h0);
        tick(1);
        chk("seq0_wait_req", {31'd0, imem_req}, 32'h0);
        chk("seq0_wait_valid", {31'd0, instr_valid}, 32'h0);
        tick(1);
        chk("seq0_valid", {31'd0, instr_valid}, 32'h1);
        chk("seq0_instr", instr, 32'h0010_0093);
        chk("seq0_op", {25'd0, op}, 32'h13);
        chk("seq0_pc", pc, 32'h0);
        imem_rdata = 32'h0020_0113;
        tick(1);
        chk("seq1_addr", imem_addr, 32'h4);
        chk("seq1_req", {31'd0, imem_req}, 32'h1);
        tick(2);
        chk("seq1_instr", instr, 32'h0020_0113);
        chk("seq1_pc", pc, 32'h4);
        imem_rdata = 32'h4030_D093;
        tick(1);
        chk("seq2_addr", imem_addr, 32'h8);
        tick(2);
        chk("seq2_instr", instr, 32'h4030_D093);
        chk("seq2_op", {25'd0, op}, 32'h13);
        chk("seq2_f3", {29'd0, funct3}, 32'h5);
        chk("seq2_f75", {31'd0, funct7_5}, 32'h1);
        chk("seq2_pc4", pc_plus4, 32'hC);
        tick(1);
        chk("seq3_addr", imem_addr, 32'hC);
        tick(3);
        chk("seq4_addr", imem_addr, 32'h10);

        // Taken backward branch from 0x10 by -8
        exec_done = 1'b0;
        tick(2);
        chk("br_valid_pc", pc, 32'h10);
        PCSrc = 1'b1; ImmOp = 32'hFFFF_FFF8; exec_done = 1'b1;
        tick(1);
        chk("br_taken_addr", imem_addr, 32'h8);
        chk("br_taken_pc", pc, 32'h8);
        ImmOp = 32'h8;
        tick(3);
        chk("br_fwd_addr", imem_addr, 32'h10);
        PCSrc = 1'b0;
        tick(3);
        chk("br_not_taken_addr", imem_addr, 32'h14);

        // Backpressure: ready low for 4 cycles, then slow response
        imem_ready = 1'b0; imem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("bp_req_held", {31'd0, imem_req}, 32'h1);
            chk("bp_addr_held", imem_addr, 32'h14);
        end
        imem_ready = 1'b1;
        tick(1);
        chk("bp_accept_req", {31'd0, imem_req}, 32'h0);
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("bp_no_dup_req", {31'd0, imem_req}, 32'h0);
            chk("bp_not_valid", {31'd0, instr_valid}, 32'h0);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h0030_0193;
        tick(1);
        chk("bp_valid", {31'd0, instr_valid}, 32'h1);
        chk("bp_instr", instr, 32'h0030_0193);
        imem_rvalid = 1'b0;
        tick(1);
        chk("bp_next_addr", imem_addr, 32'h18);

        // Walk to 0x20, then branch to a misaligned target
        imem_ready = 1'b1; imem_rvalid = 1'b1;
        tick(3);
        chk("walk_1c", imem_addr, 32'h1C);
        tick(3);
        chk("walk_20", imem_addr, 32'h20);
        tick(2);
        chk("mis_pre_pc", pc, 32'h20);
        PCSrc = 1'b1; ImmOp = 32'h6;
        tick(1);
        chk("mis_flag", {31'd0, misaligned}, 32'h1);
        chk("mis_pc", pc, 32'h20);
        chk("mis_valid", {31'd0, instr_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("mis_no_req", {31'd0, imem_req}, 32'h0);
            chk("mis_sticky", {31'd0, misaligned}, 32'h1);
        end

        // Reset, branch to 0xFFFF_FFFC, then wrap and stall
        rst = 1'b1;
        #1;
        chk("rst2_mis", {31'd0, misaligned}, 32'h0);
        tick(1);
        rst = 1'b0;
        PCSrc = 1'b1; ImmOp = 32'hFFFF_FFFC; exec_done = 1'b1;
        imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0040_0213;
        tick(1);
        chk("wrap_first_addr", imem_addr, 32'h0);
        tick(3);
        chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        PCSrc = 1'b0; exec_done = 1'b0;
        tick(2);
        chk("stall_pc0", pc, 32'hFFFF_FFFC);
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("stall_valid", {31'd0, instr_valid}, 32'h1);
            chk("stall_pc", pc, 32'hFFFF_FFFC);
            chk("stall_instr", instr, 32'h0040_0213);
        end
        exec_done = 1'b1;
        tick(1);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_no_mis", {31'd0, misaligned}, 32'h0);

        // Async reset while waiting for a response
        tick(3);
        chk("pre_wait_addr", imem_addr, 32'h4);
        imem_rvalid = 1'b0;
        tick(1);
        chk("in_wait_req", {31'd0, imem_req}, 32'h0);
        chk("in_wait_instr", instr, 32'hDEAD_BEEF);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_pc4", pc_plus4, 32'h4);
        chk("arst_instr", instr, 32'h13);
        chk("arst_valid", {31'd0, instr_valid}, 32'h0);
        chk("arst_req", {31'd0, imem_req}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0293;
        tick(1);
        chk("restart_req", {31'd0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        tick(2);
        chk("restart_instr", instr, 32'h0050_0293);
        chk("restart_pc", pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of `controlUnit`. It holds the program counter and issues word fetches to instruction memory over a request/response handshake. It latches each returned word into an instruction register and presents the decoded fields `op`, `funct3` and `funct7_5` to the control unit. It consumes the control unit's `PCSrc`, together with the datapath's `ImmOp`, to select the next PC when the downstream datapath retires the held instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word aligned.
- `NOP_INSTR`, default 32'h0000_0013: instruction register reset value (`addi x0,x0,0`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch byte address; always equals `pc` while `imem_req`=1.
- `imem_ready`  in  1  memory accepts the request this cycle when `imem_req`=1.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  fetched instruction word.
- `exec_done`  in  1  datapath retires the presented instruction this cycle.
- `PCSrc`  in  1  from controlUnit: 0 selects PC+4, 1 selects PC+ImmOp; sampled only with `exec_done`.
- `ImmOp`  in  32  sign-extended branch offset from the datapath.
- `instr`  out  32  instruction register.
- `op`  out  7  `instr[6:0]`.
- `funct3`  out  3  `instr[14:12]`.
- `funct7_5`  out  1  `instr[30]`.
- `pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `pc`+4, modulo 2^32.
- `instr_valid`  out  1  `instr` is a fetched instruction awaiting retirement.
- `misaligned`  out  1  sticky; next-PC target was not word aligned; fetch halted.

## Operation
- FSM states: IDLE, REQ, WAIT, VALID, HALT. `rst` forces IDLE.
- IDLE: all handshake outputs are 0. Moves to REQ on the next edge.
- REQ:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - If `imem_ready`=1, move to WAIT. Otherwise hold the request, with address stable.
  - `imem_rvalid` is ignored in REQ.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid`=1, set `instr`<=`imem_rdata` and move to VALID. Otherwise wait indefinitely.
- VALID:
  - `instr_valid`=1, and `instr`/`pc` are held stable.
  - On `exec_done`=1, compute next = `PCSrc` ? `pc`+`ImmOp` : `pc`+4. The 32-bit add wraps modulo 2^32.
  - If next[1:0]≠0: move to HALT, set `misaligned`<=1, and leave `pc` unchanged.
  - Otherwise set `pc`<=next and move to REQ.
- HALT: `instr_valid`=0 and `imem_req`=0. Exits only via `rst`.
- `exec_done` is ignored outside VALID, and `imem_rvalid` is ignored outside WAIT.
- Decoded fields are always combinational slices of `instr`, including when `instr_valid`=0.
- Memory protocol: the response arrives no earlier than the cycle after acceptance, and there is at most one outstanding request. The memory is reset by the same `rst`, so there are no stale responses after reset.

## Timing
- Reset values: `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4, `instr`=`NOP_INSTR` (so `op`=7'b0010011, `funct3`=0, `funct7_5`=0), `instr_valid`=0, `imem_req`=0, `misaligned`=0.
- Reset asserted mid-operation (any state) clears everything immediately and asynchronously. Any in-flight fetch is abandoned.
- First `imem_req` appears in the 2nd cycle after `rst` deasserts (IDLE takes one cycle).
- Best-case throughput: 3 cycles per instruction. This needs `imem_ready` in the REQ cycle, `imem_rvalid` in the next cycle, and `exec_done` in the first VALID cycle.
- `instr_valid` rises the cycle after `imem_rvalid` is sampled. It falls the cycle after `exec_done` is sampled.
- `pc` updates on the same edge that leaves VALID. The new `imem_addr` is visible in the following REQ cycle.
- Wrap-around: `pc`=32'hFFFF_FFFC with `PCSrc`=0 gives next `pc`=0, which is legal and not an error.

## Test plan
- Reset then sequential fetch: memory returns `addi` at 0, 4 and 8, with ready and rvalid immediate and `exec_done` held at 1 -> `imem_addr` sequence is 0,4,8 with 3 cycles between requests, and `op`=0x13 while valid.
- Taken branch: `pc`=0x10, `PCSrc`=1, `ImmOp`=0xFFFF_FFF8 at `exec_done` -> next `imem_addr`=0x08. Repeat with `PCSrc`=0 -> 0x14.
- Backpressure: `imem_ready` low for 4 cycles, then `imem_rvalid` delayed 3 cycles -> `imem_addr` held stable, `instr_valid` stays 0 until the cycle after `rvalid`, and no duplicate request is issued.
- Misaligned target: `pc`=0x20, `PCSrc`=1, `ImmOp`=0x6 -> `misaligned`=1, `pc` stays 0x20, and no further `imem_req` is issued until reset.
- Wrap and stall: `pc`=0xFFFF_FFFC with `PCSrc`=0 -> next `imem_addr`=0. `exec_done` held low for 5 cycles in VALID -> `instr`/`pc` unchanged and `instr_valid`=1 throughout.
- Async reset while in WAIT: assert `rst` mid-cycle -> outputs return to reset values before the next edge, and fetch restarts at `RESET_PC`.
